// File: rtl/npc_mem_pkg.sv
// +--------------------------------------------------------------------+
// | npc_mem_pkg: shared types and constants for the memory arbiter     |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`default_nettype none

package npc_mem_pkg;

  localparam int MEM_ADDR_W = 32;
  localparam int MEM_DATA_W = 32;
  localparam int MEM_MASK_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_e;

  typedef enum logic {
    GNT_IFU = 1'b0,
    GNT_LSU = 1'b1
  } grant_e;

endpackage

`default_nettype wire

// File: rtl/mem_arbiter.sv
// +--------------------------------------------------------------------+
// | mem_arbiter: IFU/LSU arbiter onto one memory port, one outstanding |
// | transaction. Macro MEM_ARB_ROUND_ROBIN_EN selects RR tie-breaking. |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`default_nettype none

module mem_arbiter
  import npc_mem_pkg::*;
#(
  parameter int ADDR_W = MEM_ADDR_W,
  parameter int DATA_W = MEM_DATA_W
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic                  ifu_req_valid,
  output logic                  ifu_req_ready,
  input  logic [ADDR_W-1:0]     ifu_addr,
  output logic                  ifu_resp_valid,
  output logic [DATA_W-1:0]     ifu_rdata,

  input  logic                  lsu_req_valid,
  output logic                  lsu_req_ready,
  input  logic [ADDR_W-1:0]     lsu_addr,
  input  logic                  lsu_wen,
  input  logic [DATA_W-1:0]     lsu_wdata,
  input  logic [MEM_MASK_W-1:0] lsu_wmask,
  output logic                  lsu_resp_valid,
  output logic [DATA_W-1:0]     lsu_rdata,

  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic                  mem_wen,
  output logic [DATA_W-1:0]     mem_wdata,
  output logic [MEM_MASK_W-1:0] mem_wmask,
  input  logic                  mem_resp_valid,
  input  logic [DATA_W-1:0]     mem_rdata
);

  state_e                  state_q, state_d;
  grant_e                  gnt_q, gnt_d;
  logic [ADDR_W-1:0]       addr_q, addr_d;
  logic                    wen_q, wen_d;
  logic [DATA_W-1:0]       wdata_q, wdata_d;
  logic [MEM_MASK_W-1:0]   wmask_q, wmask_d;
  grant_e                  gnt_sel;
  logic                    idle;
  logic                    hs;
  logic                    resp_fire;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  grant_e last_grant_q, last_grant_d;

  // On a tie the requester that did not win last time goes first.
  function automatic grant_e pick_grant(input logic ifu_v, input logic lsu_v,
                                        input grant_e last);
    if (ifu_v && lsu_v) begin
      if (last == GNT_IFU) return GNT_LSU;
      return GNT_IFU;
    end
    if (lsu_v) return GNT_LSU;
    return GNT_IFU;
  endfunction
`else
  function automatic grant_e pick_grant(input logic lsu_v);
    if (lsu_v) return GNT_LSU;
    return GNT_IFU;
  endfunction
`endif

  always_comb begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
    gnt_sel = pick_grant(ifu_req_valid, lsu_req_valid, last_grant_q);
`else
    gnt_sel = pick_grant(lsu_req_valid);
`endif
    idle          = (state_q == IDLE) && !rst;
    ifu_req_ready = idle && (gnt_sel == GNT_IFU);
    lsu_req_ready = idle && (gnt_sel == GNT_LSU);
    hs            = (ifu_req_valid && ifu_req_ready) || (lsu_req_valid && lsu_req_ready);

    mem_req_valid = (state_q == REQ) && !rst;
    mem_addr      = mem_req_valid ? addr_q  : '0;
    mem_wen       = mem_req_valid && wen_q;
    mem_wdata     = mem_req_valid ? wdata_q : '0;
    mem_wmask     = mem_req_valid ? wmask_q : '0;

    resp_fire      = (state_q == RESP) && mem_resp_valid && !rst;
    ifu_resp_valid = resp_fire && (gnt_q == GNT_IFU);
    lsu_resp_valid = resp_fire && (gnt_q == GNT_LSU);
    ifu_rdata      = ifu_resp_valid ? mem_rdata : '0;
    lsu_rdata      = lsu_resp_valid ? mem_rdata : '0;
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    addr_d  = addr_q;
    wen_d   = wen_q;
    wdata_d = wdata_q;
    wmask_d = wmask_q;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    last_grant_d = last_grant_q;
`endif
    case (state_q)
      IDLE: begin
        if (hs) begin
          state_d = REQ;
          gnt_d   = gnt_sel;
`ifdef MEM_ARB_ROUND_ROBIN_EN
          last_grant_d = gnt_sel;
`endif
          if (gnt_sel == GNT_LSU) begin
            addr_d  = lsu_addr;
            wen_d   = lsu_wen;
            wdata_d = lsu_wdata;
            wmask_d = lsu_wmask;
          end else begin
            addr_d  = ifu_addr;
            wen_d   = 1'b0;
            wdata_d = '0;
            wmask_d = '0;
          end
        end
      end
      REQ:     if (mem_req_ready)  state_d = RESP;
      RESP:    if (mem_resp_valid) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= GNT_IFU;
      addr_q  <= '0;
      wen_q   <= 1'b0;
      wdata_q <= '0;
      wmask_q <= '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      last_grant_q <= GNT_IFU;
`endif
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      addr_q  <= addr_d;
      wen_q   <= wen_d;
      wdata_q <= wdata_d;
      wmask_q <= wmask_d;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      last_grant_q <= last_grant_d;
`endif
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// +--------------------------------------------------------------------+
// | tb_mem_arbiter: directed scoreboard bench for mem_arbiter          |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        ifu_req_valid, ifu_req_ready, ifu_resp_valid;
  logic [31:0] ifu_addr, ifu_rdata;
  logic        lsu_req_valid, lsu_req_ready, lsu_wen, lsu_resp_valid;
  logic [31:0] lsu_addr, lsu_wdata, lsu_rdata;
  logic [7:0]  lsu_wmask;
  logic        mem_req_valid, mem_req_ready, mem_wen, mem_resp_valid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [7:0]  mem_wmask;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
    .ifu_resp_valid(ifu_resp_valid), .ifu_rdata(ifu_rdata),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
    .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
    .lsu_resp_valid(lsu_resp_valid), .lsu_rdata(lsu_rdata),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
    .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata)
  );

  typedef struct {
    bit          lsu;
    bit          chk_data;
    logic [31:0] rdata;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Response monitor: every resp pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (ifu_resp_valid || lsu_resp_valid) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_resp ifu=%0b lsu=%0b expected no response t=%0t",
                 ifu_resp_valid, lsu_resp_valid, $time);
      end else begin
        e = sb.pop_front();
        chk("resp_ifu_valid", ifu_resp_valid, !e.lsu);
        chk("resp_lsu_valid", lsu_resp_valid, e.lsu);
        if (e.chk_data) chk("resp_rdata", e.lsu ? lsu_rdata : ifu_rdata, e.rdata);
        chk("resp_other_rdata", e.lsu ? ifu_rdata : lsu_rdata, 0);
      end
    end
  end

  // Arbiter must be IDLE with requests already driven; completes one transaction.
  task automatic run_grant(input bit g_lsu, input logic [31:0] e_addr, input bit e_wen,
                           input logic [31:0] e_wdata, input logic [7:0] e_wmask,
                           input int stall, input logic [31:0] rdata, input bit chk_data);
    exp_t e;
    @(negedge clk);
    chk("grant_ifu_ready", ifu_req_ready, !g_lsu);
    chk("grant_lsu_ready", lsu_req_ready, g_lsu);
    e.lsu = g_lsu; e.chk_data = chk_data; e.rdata = rdata;
    sb.push_back(e);
    tick();
    for (int i = 0; i <= stall; i++) begin
      mem_req_ready = (i == stall);
      @(negedge clk);
      chk("mem_req_valid", mem_req_valid, 1);
      chk("mem_addr", mem_addr, e_addr);
      chk("mem_wen", mem_wen, e_wen);
      chk("mem_wdata", mem_wdata, e_wdata);
      chk("mem_wmask", mem_wmask, e_wmask);
      chk("busy_readies", {ifu_req_ready, lsu_req_ready}, 0);
      tick();
    end
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b1;
    mem_rdata      = rdata;
    @(negedge clk);
    chk("resp_mem_req_valid", mem_req_valid, 0);
    tick();
    mem_resp_valid = 1'b0;
    mem_rdata      = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  bit g_seq [4];

  initial begin
    rst = 1'b1;
    ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0000;
    lsu_req_valid = 1'b1; lsu_addr = 32'h8000_0100; lsu_wen = 1'b1;
    lsu_wdata = 32'hFFFF_FFFF; lsu_wmask = 8'hFF;
    mem_req_ready = 1'b1; mem_resp_valid = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    tick();
    @(negedge clk);
    chk("rst_readies", {ifu_req_ready, lsu_req_ready}, 0);
    chk("rst_mem_req_valid", mem_req_valid, 0);
    chk("rst_resp_valids", {ifu_resp_valid, lsu_resp_valid}, 0);
    chk("rst_mem_addr", mem_addr, 0);
    tick();
    rst = 1'b0;
    ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_rdata = '0;
    tick();

    // IFU fetch, minimum latency
    ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0000;
    run_grant(1'b0, 32'h8000_0000, 1'b0, 32'h0, 8'h00, 0, 32'h0000_0413, 1'b1);
    ifu_req_valid = 1'b0;
    tick();

    // LSU store with a 3-cycle stall on the memory port
    lsu_req_valid = 1'b1; lsu_addr = 32'h8000_0100; lsu_wen = 1'b1;
    lsu_wdata = 32'hDEAD_BEEF; lsu_wmask = 8'h0F;
    run_grant(1'b1, 32'h8000_0100, 1'b1, 32'hDEAD_BEEF, 8'h0F, 3, 32'h5555_AAAA, 1'b0);
    lsu_req_valid = 1'b0;
    tick();

    // Simultaneous requests from reset: LSU first, IFU afterwards
    do_reset();
    ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0004;
    lsu_req_valid = 1'b1; lsu_addr = 32'h8000_0200; lsu_wen = 1'b0;
    lsu_wdata = 32'h1111_2222; lsu_wmask = 8'h00;
    run_grant(1'b1, 32'h8000_0200, 1'b0, 32'h1111_2222, 8'h00, 1, 32'hA5A5_0001, 1'b1);
    lsu_req_valid = 1'b0;
    run_grant(1'b0, 32'h8000_0004, 1'b0, 32'h0, 8'h00, 0, 32'hA5A5_0002, 1'b1);
    ifu_req_valid = 1'b0;
    tick();

    // Both requesters continuously valid for four transactions
`ifdef MEM_ARB_ROUND_ROBIN_EN
    g_seq[0] = 1'b1; g_seq[1] = 1'b0; g_seq[2] = 1'b1; g_seq[3] = 1'b0;
`else
    g_seq[0] = 1'b1; g_seq[1] = 1'b1; g_seq[2] = 1'b1; g_seq[3] = 1'b1;
`endif
    do_reset();
    ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0010;
    lsu_req_valid = 1'b1; lsu_addr = 32'h8000_0300; lsu_wen = 1'b0;
    lsu_wdata = 32'h0; lsu_wmask = 8'h00;
    for (int i = 0; i < 4; i++) begin
      if (g_seq[i])
        run_grant(1'b1, 32'h8000_0300, 1'b0, 32'h0, 8'h00, 0, 32'h0000_1000 + i, 1'b1);
      else
        run_grant(1'b0, 32'h8000_0010, 1'b0, 32'h0, 8'h00, 0, 32'h0000_1000 + i, 1'b1);
    end
    ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
    tick();

    // Reset while waiting for the response, then a late response
    ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0008;
    @(negedge clk);
    chk("rr_ifu_ready", ifu_req_ready, 1);
    tick();
    ifu_req_valid = 1'b0; mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0; rst = 1'b1;
    @(negedge clk);
    chk("rst_resp_readies", {ifu_req_ready, lsu_req_ready}, 0);
    chk("rst_resp_mem_req_valid", mem_req_valid, 0);
    tick();
    rst = 1'b0; mem_resp_valid = 1'b1; mem_rdata = 32'hBAD0_BAD0;
    @(negedge clk);
    chk("late_resp_valids", {ifu_resp_valid, lsu_resp_valid}, 0);
    chk("late_mem_req_valid", mem_req_valid, 0);
    chk("late_one_ready", ifu_req_ready ^ lsu_req_ready, 1);
    tick();
    mem_resp_valid = 1'b0; mem_rdata = '0;
    ifu_req_valid = 1'b1; ifu_addr = 32'h8000_000C;
    run_grant(1'b0, 32'h8000_000C, 1'b0, 32'h0, 8'h00, 0, 32'h0010_0073, 1'b1);
    ifu_req_valid = 1'b0;
    tick();

    // Spurious memory response while idle
    mem_resp_valid = 1'b1; mem_rdata = 32'h1234_5678;
    @(negedge clk);
    chk("spur_resp_valids", {ifu_resp_valid, lsu_resp_valid}, 0);
    chk("spur_ifu_rdata", ifu_rdata, 0);
    chk("spur_lsu_rdata", lsu_rdata, 0);
    chk("spur_mem_fields", {mem_addr, mem_wdata}, 0);
    tick();
    mem_resp_valid = 1'b0; mem_rdata = '0;
    @(negedge clk);
    chk("idle_after_spur", mem_req_valid, 0);
    tick();
    tick();
    chk("sb_empty", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32: byte address width of all address ports.
REQ-002 Parameter DATA_W, default 32: data width; the write mask width SHALL be 8 (codebase mask format, low DATA_W/8 bits significant).
REQ-003 The block SHALL use one clock; reset is synchronous and active-high.
REQ-004 clk  in  1  clock, all state on posedge.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 ifu_req_valid  in  1  fetch request valid; ifu_req_ready  out  1  fetch request accepted.
REQ-007 ifu_addr  in  ADDR_W  fetch address.
REQ-008 ifu_resp_valid  out  1  fetch data valid, one-cycle pulse; ifu_rdata  out  DATA_W  fetch data.
REQ-009 lsu_req_valid  in  1  load/store request valid; lsu_req_ready  out  1  load/store request accepted.
REQ-010 lsu_addr  in  ADDR_W; lsu_wen  in  1  store when 1; lsu_wdata  in  DATA_W; lsu_wmask  in  8.
REQ-011 lsu_resp_valid  out  1  load data or store ack, one-cycle pulse; lsu_rdata  out  DATA_W.
REQ-012 mem_req_valid  out  1; mem_req_ready  in  1; mem_addr  out  ADDR_W; mem_wen  out  1; mem_wdata  out  DATA_W; mem_wmask  out  8.
REQ-013 mem_resp_valid  in  1; mem_rdata  in  DATA_W: shared memory port response.

Function
REQ-014 The FSM SHALL have states IDLE, REQ, RESP; at most one transaction SHALL be outstanding.
REQ-015 In IDLE, the arbiter SHALL grant one requester combinationally; only the granted requester's *_req_ready is 1, the other's is 0; in REQ and RESP both readies are 0.
REQ-016 On a handshake (valid&ready) in IDLE, the arbiter SHALL latch the grant, address, wen, wdata, wmask (IFU: wen=0, wmask=0, wdata=0) and go to REQ next cycle.
REQ-017 In REQ, mem_req_valid SHALL be 1 with the latched fields stable until mem_req_ready=1, then the FSM goes to RESP.
REQ-018 In RESP, on mem_resp_valid=1 the arbiter SHALL pulse the granted requester's resp_valid with rdata=mem_rdata in the same cycle (combinational pass-through) and return to IDLE next cycle.
REQ-019 Minimum latency: request handshake in cycle N, mem_req_valid in N+1, response earliest N+2 if mem_req_ready=1 at N+1.
REQ-020 mem_resp_valid outside RESP SHALL be ignored; the non-granted resp_valid SHALL stay 0.
REQ-021 Stores SHALL receive an lsu_resp_valid ack; lsu_rdata is don't-care for stores.
REQ-022 Without REQ-028 macro, simultaneous requests SHALL grant LSU (fixed priority).
REQ-023 *_rdata SHALL be mem_rdata when the corresponding resp_valid is 1, else 0.
REQ-024 mem_addr/mem_wdata/mem_wmask/mem_wen SHALL be 0 when mem_req_valid is 0.

Reset
REQ-025 rst SHALL force state IDLE, clear latched request fields and last_grant (=IFU); all *_valid and *_ready outputs SHALL be 0 in the reset cycle.
REQ-026 rst mid-transaction (REQ or RESP) SHALL abandon it with no resp pulse; a late mem_resp_valid after reset SHALL be ignored.
REQ-027 Reset SHALL override any handshake in the same cycle; no request is accepted while rst=1.

Configuration
REQ-028 Macro MEM_ARB_ROUND_ROBIN_EN: when defined, simultaneous requests SHALL grant the requester not granted last (last_grant register updated on each handshake; reset value IFU so first tie goes to LSU); single requests are granted unconditionally.
REQ-029 When MEM_ARB_ROUND_ROBIN_EN is undefined, no last_grant register SHALL exist and REQ-022 applies.

Structure
REQ-030 Package npc_mem_pkg SHALL hold the FSM state enum (IDLE/REQ/RESP), grant enum (GNT_IFU/GNT_LSU), and constants MEM_ADDR_W, MEM_DATA_W, MEM_MASK_W=8.
REQ-031 The block SHALL be a single module; no sub-module is needed, grant selection is an internal combinational function.

Verification
REQ-032 IFU only, addr 0x8000_0000, mem_req_ready=1, mem_resp_valid at N+2 with rdata 0x0000_0413 -> ifu_resp_valid pulse at N+2, ifu_rdata 0x0000_0413, lsu_resp_valid 0.
REQ-033 LSU store addr 0x8000_0100, wdata 0xDEAD_BEEF, wmask 0x0F -> mem_wen=1, fields on mem port held while mem_req_ready=0 for 3 cycles, single lsu_resp_valid ack.
REQ-034 IFU and LSU valid same cycle, macro off -> LSU granted, ifu_req_ready 0 until LSU response; IFU granted in the following IDLE.
REQ-035 Macro on, both requesters valid continuously for 4 transactions -> grants LSU, IFU, LSU, IFU.
REQ-036 rst asserted in RESP, then mem_resp_valid pulsed -> no resp_valid on either port, state IDLE, next IFU request served normally.
REQ-037 Spurious mem_resp_valid in IDLE with 0x1234_5678 -> no resp_valid, rdata outputs 0.
